// File: rtl/sram_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sram_write_scheduler
// Purpose  : Round-robin, burst-bounded merge of the background (w0) and
//            overlay (w1) write streams onto one registered SRAM write port.
//            Optional statistics outputs: define SRAM_WRITE_SCHED_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module sram_write_scheduler #(
  parameter int BURST_LEN = 16,
  parameter int WORD_W    = 54
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [WORD_W-1:0] w0_din_i,
  input  logic              w0_valid_i,
  output logic              w0_ready_o,
  input  logic [WORD_W-1:0] w1_din_i,
  input  logic              w1_valid_i,
  output logic              w1_ready_o,
  output logic [WORD_W-1:0] dout_o,
  output logic              dout_valid_o,
  input  logic              dout_ready_i,
`ifdef SRAM_WRITE_SCHED_STATS_EN
  output logic [31:0]       w0_beats_o,
  output logic [31:0]       w1_beats_o,
  output logic [15:0]       starve_o,
`endif
  output logic              grant_o
);

  localparam logic [7:0] CNT_LAST = 8'(BURST_LEN - 1);

  typedef enum logic {
    G0 = 1'b0,
    G1 = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [WORD_W-1:0]   dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;

  logic                space;
  logic                cur_valid;
  logic                other_valid;
  logic [WORD_W-1:0]   cur_din;
  logic                accept;
  logic                burst_done;
  logic                switch_req;

  // Readies depend only on registered state and dout_ready, never on valids.
  assign space       = !dout_valid_q || dout_ready_i;
  assign w0_ready_o  = (state_q == G0) && space;
  assign w1_ready_o  = (state_q == G1) && space;

  assign cur_valid   = (state_q == G0) ? w0_valid_i : w1_valid_i;
  assign other_valid = (state_q == G0) ? w1_valid_i : w0_valid_i;
  assign cur_din     = (state_q == G0) ? w0_din_i   : w1_din_i;

  assign accept      = cur_valid && space;
  assign burst_done  = accept && (cnt_q == CNT_LAST);
  assign switch_req  = (burst_done && other_valid) || (!cur_valid && other_valid);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;

    if (accept) begin
      dout_d       = cur_din;
      dout_valid_d = 1'b1;
      cnt_d        = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;
    end else if (dout_ready_i) begin
      dout_valid_d = 1'b0;
    end

    // An idle owner yields even under backpressure; the count restarts.
    if (switch_req) begin
      state_d = (state_q == G0) ? G1 : G0;
      cnt_d   = 8'd0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= G0;
      cnt_q        <= 8'd0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign grant_o      = (state_q == G1);

`ifdef SRAM_WRITE_SCHED_STATS_EN
  logic [31:0] w0_beats_q, w0_beats_d;
  logic [31:0] w1_beats_q, w1_beats_d;
  logic [15:0] w0_wait_q, w0_wait_d;
  logic [15:0] w1_wait_q, w1_wait_d;
  logic [15:0] starve_q, starve_d;

  // A requester is waiting while it is valid and does not own the port.
  always_comb begin
    w0_beats_d = w0_beats_q;
    w1_beats_d = w1_beats_q;
    w0_wait_d  = 16'd0;
    w1_wait_d  = 16'd0;
    starve_d   = starve_q;

    if (accept && (state_q == G0)) w0_beats_d = w0_beats_q + 32'd1;
    if (accept && (state_q == G1)) w1_beats_d = w1_beats_q + 32'd1;

    if (w0_valid_i && (state_q != G0))
      w0_wait_d = (w0_wait_q == 16'hFFFF) ? w0_wait_q : w0_wait_q + 16'd1;
    if (w1_valid_i && (state_q != G1))
      w1_wait_d = (w1_wait_q == 16'hFFFF) ? w1_wait_q : w1_wait_q + 16'd1;

    if (w0_wait_d > starve_d) starve_d = w0_wait_d;
    if (w1_wait_d > starve_d) starve_d = w1_wait_d;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      w0_beats_q <= 32'd0;
      w1_beats_q <= 32'd0;
      w0_wait_q  <= 16'd0;
      w1_wait_q  <= 16'd0;
      starve_q   <= 16'd0;
    end else begin
      w0_beats_q <= w0_beats_d;
      w1_beats_q <= w1_beats_d;
      w0_wait_q  <= w0_wait_d;
      w1_wait_q  <= w1_wait_d;
      starve_q   <= starve_d;
    end
  end

  assign w0_beats_o = w0_beats_q;
  assign w1_beats_o = w1_beats_q;
  assign starve_o   = starve_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_write_scheduler
// Purpose  : Self-checking bench for sram_write_scheduler (BURST_LEN = 4).
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_write_scheduler;

  localparam int BURST = 4;
  localparam int W     = 54;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] w0_din, w1_din, dout;
  logic         w0_valid, w1_valid, w0_ready, w1_ready;
  logic         dout_valid, dout_ready, grant;
`ifdef SRAM_WRITE_SCHED_STATS_EN
  logic [31:0]  w0_beats, w1_beats;
  logic [15:0]  starve;
`endif

  always #5 clock = ~clock;

  sram_write_scheduler #(.BURST_LEN(BURST), .WORD_W(W)) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .w0_din_i     (w0_din),
    .w0_valid_i   (w0_valid),
    .w0_ready_o   (w0_ready),
    .w1_din_i     (w1_din),
    .w1_valid_i   (w1_valid),
    .w1_ready_o   (w1_ready),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .dout_ready_i (dout_ready),
`ifdef SRAM_WRITE_SCHED_STATS_EN
    .w0_beats_o   (w0_beats),
    .w1_beats_o   (w1_beats),
    .starve_o     (starve),
`endif
    .grant_o      (grant)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  int           seq0, seq1;
  bit           v0, v1, dr;
  bit           acc0, acc1, fire, sb_have;
  bit           rnd_mode = 1'b0;
  int           p_valid = 60;
  int           p_ready = 70;
  logic [W-1:0] cur0, cur1, sb_exp;
  logic [W-1:0] sb0[$];
  logic [W-1:0] sb1[$];

  // Bit 31 of the data field tags the source stream.
  function automatic logic [W-1:0] mkword(input int s, input int q);
    logic [3:0]  m;
    logic [17:0] a;
    logic [31:0] d;
    m = 4'(q + s);
    a = 18'(q * 7 + s * 1000 + 5);
    d = {s[0], 31'(q * 3 + 1)};
    return {m, a, d};
  endfunction

  function automatic logic [W-1:0] gen(input int s, input int q);
    logic [W-1:0] w;
    w = mkword(s, q);
    if (rnd_mode) begin
      w[30:0]  = 31'($urandom());
      w[53:32] = 22'($urandom());
    end
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    v0 = 0; v1 = 0; dr = 0;
    w0_valid = 0; w1_valid = 0; dout_ready = 0;
    acc0 = 0; acc1 = 0; seq0 = 0; seq1 = 0;
    cur0 = gen(0, 0); cur1 = gen(1, 0);
    w0_din = cur0; w1_din = cur1;
    sb0.delete(); sb1.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One clock: apply inputs at negedge, record handshakes 1 ns later.
  task automatic cycle();
    @(negedge clock);
    if (acc0) begin seq0++; cur0 = gen(0, seq0); end
    if (acc1) begin seq1++; cur1 = gen(1, seq1); end
    if (rnd_mode) begin
      if (!w0_valid || acc0) w0_valid = ($urandom_range(0, 99) < p_valid);
      if (!w1_valid || acc1) w1_valid = ($urandom_range(0, 99) < p_valid);
      dout_ready = ($urandom_range(0, 99) < p_ready);
    end else begin
      w0_valid = v0; w1_valid = v1; dout_ready = dr;
    end
    w0_din = cur0; w1_din = cur1;
    #1;
    acc0 = w0_valid && w0_ready;
    acc1 = w1_valid && w1_ready;
    if (acc0) sb0.push_back(w0_din);
    if (acc1) sb1.push_back(w1_din);
    fire = dout_valid && dout_ready;
    sb_have = 0; sb_exp = '0;
    if (fire) begin
      if (!dout[31] && sb0.size() > 0) begin sb_exp = sb0.pop_front(); sb_have = 1; end
      else if (dout[31] && sb1.size() > 0) begin sb_exp = sb1.pop_front(); sb_have = 1; end
    end
  endtask

  task automatic test_reset();
    w0_valid = 0; w1_valid = 0; dout_ready = 0; w0_din = '0; w1_din = '0;
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if ({dout_valid, grant, w0_ready, w1_ready} !== 4'b0010) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0010", {dout_valid, grant, w0_ready, w1_ready});
    end
    n_tests++;
    if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
    n_tests++;
    if (dut.cnt_q !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q); end
    do_reset();
  endtask

  task automatic test_w0_only();
    int nfire = 0;
    do_reset();
    v0 = 1; v1 = 0; dr = 1;
    for (int k = 0; k < 21; k++) begin
      cycle();
      n_tests++;
      if ({grant, w0_ready, w1_ready, dout_valid} !== {3'b010, 1'(k > 0)}) begin
        n_fail++; $display("FAIL w0only_flags k=%0d: got %b want %b", k,
                           {grant, w0_ready, w1_ready, dout_valid}, {3'b010, 1'(k > 0)});
      end
      if (k > 0) begin
        n_tests++;
        if (dout !== mkword(0, k - 1)) begin
          n_fail++; $display("FAIL w0only_dout k=%0d: got %h want %h", k, dout, mkword(0, k - 1));
        end
      end
      if (fire) nfire++;
    end
    n_tests++;
    if (nfire != 20) begin n_fail++; $display("FAIL w0only_count: got %0d want 20", nfire); end
  endtask

  task automatic test_round_robin();
    int j, src, q;
    logic eg;
    do_reset();
    v0 = 1; v1 = 1; dr = 1;
    for (int k = 0; k < 24; k++) begin
      cycle();
      eg = 1'((k / BURST) % 2);
      n_tests++;
      if ({grant, w0_ready, w1_ready, dout_valid} !== {eg, !eg, eg, 1'(k > 0)}) begin
        n_fail++; $display("FAIL rr_flags k=%0d: got %b want %b", k,
                           {grant, w0_ready, w1_ready, dout_valid}, {eg, !eg, eg, 1'(k > 0)});
      end
      if (k > 0) begin
        j   = k - 1;
        src = (j / BURST) % 2;
        q   = (j / (2 * BURST)) * BURST + j % BURST;
        n_tests++;
        if (dout !== mkword(src, q)) begin
          n_fail++; $display("FAIL rr_dout k=%0d: got %h want %h", k, dout, mkword(src, q));
        end
      end
    end
  endtask

  task automatic test_w1_only();
    logic [3:0] ef;
    do_reset();
    v0 = 0; v1 = 1; dr = 1;
    for (int k = 0; k < 10; k++) begin
      cycle();
      ef = (k == 0) ? 4'b0100 : (k == 1) ? 4'b1010 : 4'b1011;
      n_tests++;
      if ({grant, w0_ready, w1_ready, dout_valid} !== ef) begin
        n_fail++; $display("FAIL w1only_flags k=%0d: got %b want %b", k,
                           {grant, w0_ready, w1_ready, dout_valid}, ef);
      end
      if (k >= 2) begin
        n_tests++;
        if (dout !== mkword(1, k - 2)) begin
          n_fail++; $display("FAIL w1only_dout k=%0d: got %h want %h", k, dout, mkword(1, k - 2));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int nacc = 0, nfire = 0;
    do_reset();
    v0 = 1; v1 = 1; dr = 1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      nacc += int'(acc0) + int'(acc1);
      if (fire) nfire++;
    end
    dr = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      n_tests++;
      if ({dout_valid, w0_ready, w1_ready, grant} !== 4'b1000) begin
        n_fail++; $display("FAIL bp_flags k=%0d: got %b want 1000", k, {dout_valid, w0_ready, w1_ready, grant});
      end
      n_tests++;
      if (dout !== mkword(0, 1)) begin
        n_fail++; $display("FAIL bp_hold k=%0d: got %h want %h", k, dout, mkword(0, 1));
      end
      n_tests++;
      if (dut.cnt_q !== 8'd2) begin n_fail++; $display("FAIL bp_cnt k=%0d: got %0d want 2", k, dut.cnt_q); end
    end
    dr = 1;
    for (int k = 0; k < 24; k++) begin
      if (k == 20) begin v0 = 0; v1 = 0; end
      cycle();
      nacc += int'(acc0) + int'(acc1);
      if (fire) begin
        nfire++;
        n_tests++;
        if (!sb_have || dout !== sb_exp) begin
          n_fail++; $display("FAIL bp_scoreboard k=%0d: got %h want %h (have=%0b)", k, dout, sb_exp, sb_have);
        end
      end
    end
    n_tests++;
    if (nfire != nacc || sb0.size() != 0 || sb1.size() != 0) begin
      n_fail++; $display("FAIL bp_totals: out %0d in %0d left %0d/%0d, want all out", nfire, nacc, sb0.size(), sb1.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    v0 = 1; v1 = 1; dr = 1;
    for (int k = 0; k < 7; k++) cycle();
    n_tests++;
    if ({grant, dut.cnt_q, dout_valid} !== {1'b1, 8'd2, 1'b1}) begin
      n_fail++; $display("FAIL arst_pre: got g=%0b cnt=%0d dv=%0b want g=1 cnt=2 dv=1", grant, dut.cnt_q, dout_valid);
    end
    #1 reset = 1'b1;
    #1;
    n_tests++;
    if ({grant, dut.cnt_q, dout_valid, w0_ready, w1_ready} !== {1'b0, 8'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL arst_post: got g=%0b cnt=%0d dv=%0b r=%0b%0b want g=0 cnt=0 dv=0 r=10",
                         grant, dut.cnt_q, dout_valid, w0_ready, w1_ready);
    end
    n_tests++;
    if (dout !== '0) begin n_fail++; $display("FAIL arst_dout: got %h want 0", dout); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_random();
    int           m_own, m_cnt;
    bit           m_dv, space, cur_v, oth_v, take, full;
    logic [W-1:0] m_dout;
    do_reset();
    rnd_mode = 1;
    cur0 = gen(0, 0); cur1 = gen(1, 0);
    m_own = 0; m_cnt = 0; m_dv = 0; m_dout = '0;
    for (int k = 0; k < 400; k++) begin
      cycle();
      space = !m_dv || dout_ready;
      n_tests++;
      if ({grant, w0_ready, w1_ready, dout_valid} !== {m_own[0], 1'(m_own == 0 && space), 1'(m_own == 1 && space), m_dv}) begin
        n_fail++; $display("FAIL rand_flags k=%0d: got %b want %b", k, {grant, w0_ready, w1_ready, dout_valid},
                           {m_own[0], 1'(m_own == 0 && space), 1'(m_own == 1 && space), m_dv});
      end
      if (m_dv) begin
        n_tests++;
        if (dout !== m_dout) begin n_fail++; $display("FAIL rand_dout k=%0d: got %h want %h", k, dout, m_dout); end
      end
      if (fire) begin
        n_tests++;
        if (!sb_have || dout !== sb_exp) begin
          n_fail++; $display("FAIL rand_scoreboard k=%0d: got %h want %h (have=%0b)", k, dout, sb_exp, sb_have);
        end
      end
      cur_v = (m_own == 0) ? w0_valid : w1_valid;
      oth_v = (m_own == 0) ? w1_valid : w0_valid;
      take  = cur_v && space;
      full  = take && (m_cnt == BURST - 1);
      if (take) begin
        m_dout = (m_own == 0) ? w0_din : w1_din;
        m_dv   = 1;
        m_cnt  = (m_cnt + 1) % BURST;
      end else if (dout_ready) begin
        m_dv = 0;
      end
      if ((full && oth_v) || (!cur_v && oth_v)) begin
        m_own = 1 - m_own;
        m_cnt = 0;
      end
    end
    rnd_mode = 0;
    v0 = 0; v1 = 0; dr = 1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (fire) begin
        n_tests++;
        if (!sb_have || dout !== sb_exp) begin
          n_fail++; $display("FAIL rand_drain k=%0d: got %h want %h", k, dout, sb_exp);
        end
      end
    end
    n_tests++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_fail++; $display("FAIL rand_leftover: got %0d/%0d words undelivered want 0/0", sb0.size(), sb1.size());
    end
  endtask

`ifdef SRAM_WRITE_SCHED_STATS_EN
  task automatic test_stats();
    do_reset();
    v0 = 1; v1 = 1; dr = 1;
    for (int k = 0; k < 40; k++) cycle();
    v0 = 0; v1 = 0;
    cycle();
    n_tests++;
    if (w0_beats !== 32'd20 || w1_beats !== 32'd20) begin
      n_fail++; $display("FAIL stats_beats: got %0d/%0d want 20/20", w0_beats, w1_beats);
    end
    n_tests++;
    if (starve !== 16'(BURST)) begin n_fail++; $display("FAIL stats_starve: got %0d want %0d", starve, BURST); end
  endtask
`endif

  initial begin
    test_reset();
    test_w0_only();
    test_round_robin();
    test_w1_only();
    test_backpressure();
    test_async_reset();
    test_random();
`ifdef SRAM_WRITE_SCHED_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
